// File: rtl/alu_share_arbiter.sv
// Round-robin share of one single-cycle ALU among NUM_REQ requesters, one-entry response buffer.
// Latency 1 cycle accept->response; no request accepted while the buffer is full and rsp_ready is low.
package alu_share_pkg;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  alu_ctrl_t;

    localparam alu_ctrl_t ALU_AND = 4'h0;
    localparam alu_ctrl_t ALU_OR  = 4'h1;
    localparam alu_ctrl_t ALU_ADD = 4'h2;
    localparam alu_ctrl_t ALU_SUB = 4'h6;
endpackage

module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  alu_ctrl_t [NUM_REQ-1:0]   req_alu_ctrl,
    input  word_t [NUM_REQ-1:0]       req_rd1,
    input  word_t [NUM_REQ-1:0]       req_rd2,
    input  word_t [NUM_REQ-1:0]       req_imm32,
    input  logic [NUM_REQ-1:0]        req_alu_src,
    output alu_ctrl_t                 alu_ctrl_o,
    output word_t                     alu_rd1_o,
    output word_t                     alu_rd2_o,
    output word_t                     alu_imm32_o,
    output logic                      alu_src_o,
    input  word_t                     alu_out_i,
    input  logic                      alu_zero_i,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output word_t                     rsp_result,
    output logic                      rsp_zero
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic            slot_free;
    logic            accept;
    int              idx;

    assign slot_free = !rsp_valid || rsp_ready;
    assign accept    = gnt_any && slot_free;

    // Scan from the farthest offset down so the closest valid index to rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        alu_ctrl_o  = ALU_ADD;
        alu_rd1_o   = '0;
        alu_rd2_o   = '0;
        alu_imm32_o = '0;
        alu_src_o   = 1'b0;
        if (gnt_any) begin
            alu_ctrl_o  = req_alu_ctrl[gnt_id];
            alu_rd1_o   = req_rd1[gnt_id];
            alu_rd2_o   = req_rd2[gnt_id];
            alu_imm32_o = req_imm32[gnt_id];
            alu_src_o   = req_alu_src[gnt_id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rr_ptr     <= '0;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= gnt_id;
            rsp_result <= alu_out_i;
            rsp_zero   <= alu_zero_i;
            rr_ptr     <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a cycle-level reference model.
// The bench also plays the ALU: SUB is b-a and the zero flag reports operand a == operand b.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int N  = 2;
    localparam int IW = $clog2(N);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req_valid = '0;
    logic [N-1:0]       req_ready;
    alu_ctrl_t [N-1:0]  req_alu_ctrl = '0;
    word_t [N-1:0]      req_rd1 = '0;
    word_t [N-1:0]      req_rd2 = '0;
    word_t [N-1:0]      req_imm32 = '0;
    logic [N-1:0]       req_alu_src = '0;
    alu_ctrl_t          alu_ctrl_o;
    word_t              alu_rd1_o, alu_rd2_o, alu_imm32_o;
    logic               alu_src_o;
    word_t              alu_out_i;
    logic               alu_zero_i;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [IW-1:0]      rsp_id;
    word_t              rsp_result;
    logic               rsp_zero;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alu_ctrl(req_alu_ctrl), .req_rd1(req_rd1), .req_rd2(req_rd2),
        .req_imm32(req_imm32), .req_alu_src(req_alu_src),
        .alu_ctrl_o(alu_ctrl_o), .alu_rd1_o(alu_rd1_o), .alu_rd2_o(alu_rd2_o),
        .alu_imm32_o(alu_imm32_o), .alu_src_o(alu_src_o),
        .alu_out_i(alu_out_i), .alu_zero_i(alu_zero_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    function automatic word_t alu_f(alu_ctrl_t c, word_t a, word_t b);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return b - a;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            default: return '0;
        endcase
    endfunction

    word_t alu_b;
    assign alu_b      = alu_src_o ? alu_imm32_o : alu_rd2_o;
    assign alu_out_i  = alu_f(alu_ctrl_o, alu_rd1_o, alu_b);
    assign alu_zero_i = (alu_rd1_o == alu_b);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference state: response buffer contents and the next-priority index.
    bit    m_valid;
    int    m_id;
    word_t m_res;
    bit    m_zero;
    int    m_ptr;
    int    acc_q[$];
    int    last_acc = -1;

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_ptr = 0;
    endtask

    task automatic set_req(input int i, input bit v, input alu_ctrl_t c,
                           input word_t a, input word_t b, input word_t imm, input bit src);
        req_valid[i] = v; req_alu_ctrl[i] = c; req_rd1[i] = a;
        req_rd2[i] = b; req_imm32[i] = imm; req_alu_src[i] = src;
    endtask

    // One clock: check outputs at negedge, advance the model at posedge, return 1 after it.
    task automatic cycle();
        int           g;
        bit           sf;
        logic [N-1:0] er;
        word_t        b;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        sf = !m_valid || rsp_ready;
        er = '0;
        if (g >= 0 && sf) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        if (g >= 0) begin
            chk("alu_ctrl", alu_ctrl_o, req_alu_ctrl[g]);
            chk("alu_rd1", alu_rd1_o, req_rd1[g]);
            chk("alu_rd2", alu_rd2_o, req_rd2[g]);
            chk("alu_imm", alu_imm32_o, req_imm32[g]);
            chk("alu_src", alu_src_o, req_alu_src[g]);
        end else begin
            chk("idle_ctrl", alu_ctrl_o, ALU_ADD);
            chk("idle_ops", alu_rd1_o | alu_rd2_o | alu_imm32_o, 0);
            chk("idle_src", alu_src_o, 0);
        end
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_zero", rsp_zero, m_zero);
        @(posedge clk);
        last_acc = -1;
        if (g >= 0 && sf) begin
            b       = req_alu_src[g] ? req_imm32[g] : req_rd2[g];
            m_res   = alu_f(req_alu_ctrl[g], req_rd1[g], b);
            m_zero  = (req_rd1[g] == b);
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % N;
            acc_q.push_back(g);
            last_acc = g;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    alu_ctrl_t ops [5] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, 4'hF};
    int        wait_acc [N];
    int        max_wait = 0;

    initial begin
        model_reset();
        req_valid = '1;
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_req_ready", req_ready, 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single ADD
        set_req(0, 1, ALU_ADD, 5, 7, 0, 0);
        cycle();
        chk("add_acc", last_acc, 0);
        chk("add_valid", rsp_valid, 1);
        chk("add_id", rsp_id, 0);
        chk("add_res", rsp_result, 12);
        chk("add_zero", rsp_zero, 0);
        set_req(0, 0, ALU_ADD, 0, 0, 0, 0);

        // immediate SUB then AND
        set_req(1, 1, ALU_SUB, 3, 0, 10, 1);
        cycle();
        chk("sub_res", rsp_result, 7);
        chk("sub_id", rsp_id, 1);
        set_req(1, 1, ALU_AND, 32'hF0, 32'hF0, 0, 0);
        cycle();
        chk("and_res", rsp_result, 32'hF0);
        chk("and_zero", rsp_zero, 1);
        set_req(1, 0, ALU_ADD, 0, 0, 0, 0);

        // round robin with both valid
        acc_q.delete();
        set_req(0, 1, ALU_ADD, 1, 1, 0, 0);
        set_req(1, 1, ALU_OR, 2, 4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_valid", rsp_valid, 1);
        end
        for (int i = 0; i < 4; i++) chk("rr_order", acc_q[i], i % 2);
        req_valid = '0;

        // backpressure
        set_req(0, 1, ALU_ADD, 1, 2, 0, 0);
        cycle();
        chk("bp_acc0", last_acc, 0);
        set_req(0, 0, ALU_ADD, 0, 0, 0, 0);
        set_req(1, 1, ALU_ADD, 100, 23, 0, 0);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_noacc", last_acc, -1);
            chk("bp_hold", rsp_result, 3);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_acc1", last_acc, 1);
        chk("bp_res", rsp_result, 123);
        chk("bp_id", rsp_id, 1);

        // reset with a response pending and pointer at 1
        set_req(1, 0, ALU_ADD, 0, 0, 0, 0);
        set_req(0, 1, ALU_ADD, 9, 9, 0, 0);
        cycle();
        chk("pre_rst_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_res", rsp_result, 0);
        chk("mid_rst_ready", req_ready, 0);
        model_reset();
        set_req(1, 1, ALU_SUB, 4, 6, 0, 0);
        #2 rst_n = 1'b1;
        cycle();
        chk("post_rst_first", last_acc, 0);
        req_valid = '0;

        // idle then check the pointer did not move
        for (int i = 0; i < 5; i++) cycle();
        chk("idle_valid", rsp_valid, 0);
        req_valid = '1;
        cycle();
        chk("idle_ptr", last_acc, 1);
        req_valid = '0;

        // randomized traffic
        for (int i = 0; i < N; i++) wait_acc[i] = 0;
        for (int t = 0; t < 400; t++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_acc == i) begin
                    set_req(i, $urandom_range(0, 2) != 0, ops[$urandom_range(0, 4)],
                            $urandom_range(0, 7), $urandom_range(0, 7),
                            ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 7)),
                            $urandom_range(0, 1) != 0);
                end
            end
            cycle();
            for (int i = 0; i < N; i++) begin
                if (last_acc == i || !req_valid[i]) wait_acc[i] = 0;
                else if (last_acc >= 0) wait_acc[i]++;
                if (wait_acc[i] > max_wait) max_wait = wait_acc[i];
            end
        end
        chk("starve_bound", max_wait < N, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
